chunked_borrow_subtractor: RTL and testbench

- Multi-cycle N-bit subtractor computing result = input1 - input2 - bin.
- Processes K bits per clock, least-significant chunk first, rippling the borrow through a single K-bit chunk datapath.
- Used where a full-width subtract does not meet timing; it is the subtract counterpart of the team's ripple-carry adders.
- Valid/ready handshake on both input and output sides.

---
 rtl/chunked_borrow_subtractor.sv | 142 ++++++++++++++
 tb/tb_chunked_borrow_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_borrow_subtractor.sv
// ============================================================================
// Module  : chunked_borrow_subtractor
// Brief   : Multi-cycle N-bit subtractor (input1 - input2 - bin), K bits per
//           clock, LS chunk first. Optional signed overflow flag via the
//           SUB_SIGNED_FLAGS_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunked_borrow_subtractor #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic         bout,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SUB_SIGNED_FLAGS_EN
  ,
  output logic         ovf
`endif
);

  localparam int CHUNKS = N / K;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);
  localparam logic [N-1:0] CHUNK_MASK = N'({K{1'b1}});

  generate
    if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_check
      $error("chunked_borrow_subtractor: N must be a positive multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  diff_reg;
  logic          borrow;
  logic [IW-1:0] idx;

  logic [31:0]   bit_base;
  logic [N-1:0]  a_shift;
  logic [N-1:0]  b_shift;
  logic [K-1:0]  a_chunk;
  logic [K-1:0]  b_chunk;
  logic [K:0]    chunk_sub;
  logic [N-1:0]  diff_next;

  // Shifts rather than indexed part-selects keep the chunk mux width-clean.
  assign bit_base  = 32'(idx) * 32'(K);
  assign a_shift   = a_reg >> bit_base;
  assign b_shift   = b_reg >> bit_base;
  assign a_chunk   = a_shift[K-1:0];
  assign b_chunk   = b_shift[K-1:0];
  assign chunk_sub = {1'b0, a_chunk} - {1'b0, b_chunk} - {{K{1'b0}}, borrow};
  assign diff_next = (diff_reg & ~(CHUNK_MASK << bit_base))
                   | (N'(chunk_sub[K-1:0]) << bit_base);

`ifdef SUB_SIGNED_FLAGS_EN
  logic ovf_next;
  assign ovf_next = (a_reg[N-1] != b_reg[N-1]) && (diff_next[N-1] != a_reg[N-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_reg  <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= input1;
            b_reg    <= input2;
            borrow   <= bin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff_reg <= diff_next;
          borrow   <= chunk_sub[K];
          idx      <= idx + 1'b1;
          // Visible outputs are only ever written here, on the last chunk.
          if (idx == LAST_IDX) begin
            idx       <= '0;
            result    <= diff_next;
            bout      <= chunk_sub[K];
            zero      <= (diff_next == '0);
`ifdef SUB_SIGNED_FLAGS_EN
            ovf       <= ovf_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chunked_borrow_subtractor.sv
// ============================================================================
// Module  : tb_chunked_borrow_subtractor
// Brief   : Self-checking bench: directed vector table, multi-cycle corner
//           sequences and randomized ops against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chunked_borrow_subtractor;

  localparam int N = 32;
  localparam int K = 8;
  localparam int LAT = N / K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] input1 = '0;
  logic [N-1:0] input2 = '0;
  logic         bin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] result;
  logic         bout;
  logic         zero;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         ovf_s;

  chunked_borrow_subtractor #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .input1(input1), .input2(input2), .bin(bin),
    .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .bout(bout), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef SUB_SIGNED_FLAGS_EN
    , .ovf(ovf_s)
`endif
  );

`ifndef SUB_SIGNED_FLAGS_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: one wide subtraction; the extra top bit is the borrow.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    logic [N:0] d;
    logic       v;
    d = {1'b0, a} - {1'b0, b} - (N+1)'(c);
    v = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    return {v, d};
  endfunction

  logic [N-1:0] r_res;
  logic         r_bout, r_zero, r_ovf;
  int           r_lat;

  // Runs one op; hold = cycles out_ready stays low after out_valid.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input int hold, input string tag);
    int n;
    @(negedge clk);
    check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    input1 = a; input2 = b; bin = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    input1 = $urandom; input2 = $urandom; bin = 1'($urandom);
    r_lat = 0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    r_lat = n;
    if (n >= 50) begin
      check({tag, " timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    r_res = result; r_bout = bout; r_zero = zero; r_ovf = ovf_s;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold result"}, 64'(result), 64'(r_res));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " after handshake"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  typedef struct {
    logic [N-1:0] a, b;
    logic         c;
    logic [N-1:0] res;
    logic         bo, z;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N+1:0] m;
    logic [N-1:0] a, b;
    logic         c;
    bit           stale;

    vecs[0] = '{32'd5,         32'd3,  1'b0, 32'd2,         1'b0, 1'b0};
    vecs[1] = '{32'd0,         32'd1,  1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0100, 32'd1,  1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[3] = '{32'd10,        32'd10, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'd7,         32'd7,  1'b0, 32'd0,         1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {60'd0, in_ready, out_valid, bout, zero}, 64'h8);
    check("reset result", 64'(result), 64'd0);
    check("reset ovf", 64'(ovf_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d latency", i), 64'(r_lat), 64'(LAT));
      check($sformatf("vec%0d result", i), 64'(r_res), 64'(vecs[i].res));
      check($sformatf("vec%0d bout", i), 64'(r_bout), 64'(vecs[i].bo));
      check($sformatf("vec%0d zero", i), 64'(r_zero), 64'(vecs[i].z));
    end

    // Backpressure with in_valid held high in DONE, then a follow-up op.
    do_op(32'd20, 32'd8, 1'b0, 5, "bp");
    check("bp result", 64'(r_res), 64'd12);
    do_op(32'd9, 32'd4, 1'b0, 0, "bp2");
    check("bp2 result", 64'(r_res), 64'd5);

    // Reset two cycles into RUN aborts the op.
    @(negedge clk);
    input1 = 32'd50; input2 = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {62'd0, in_ready, out_valid}, 64'd2);
    check("abort result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("abort no stale out_valid", 64'(stale), 64'd0);
    do_op(32'd100, 32'd1, 1'b0, 0, "post_abort");
    check("post_abort result", 64'(r_res), 64'd99);

`ifdef SUB_SIGNED_FLAGS_EN
    do_op(32'h8000_0000, 32'd1, 1'b0, 0, "ovf1");
    check("ovf1 result", 64'(r_res), 64'h7FFF_FFFF);
    check("ovf1 ovf", 64'(r_ovf), 64'd1);
    check("ovf1 bout", 64'(r_bout), 64'd0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf2");
    check("ovf2 ovf", 64'(r_ovf), 64'd1);
    do_op(32'd3, 32'd1, 1'b0, 0, "ovf3");
    check("ovf3 ovf", 64'(r_ovf), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_FFFF;
      c = 1'($urandom);
      m = model(a, b, c);
      do_op(a, b, c, $urandom_range(0, 3), $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d result", i), 64'(r_res), 64'(m[N-1:0]));
      check($sformatf("rnd%0d bout", i), 64'(r_bout), 64'(m[N]));
      check($sformatf("rnd%0d zero", i), 64'(r_zero), 64'(m[N-1:0] == '0));
      check($sformatf("rnd%0d latency", i), 64'(r_lat), 64'(LAT));
`ifdef SUB_SIGNED_FLAGS_EN
      check($sformatf("rnd%0d ovf", i), 64'(r_ovf), 64'(m[N+1]));
`endif
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
